// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, bus owner and
// latency-counter sizing. The hazard unit imports the same package so that
// both blocks decode the arbiter state identically.
package mem_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // Current (or last) owner of the memory port.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Counter is sized for the largest supported latency (15).
  localparam int CNT_W   = $clog2(16);
  localparam int MAX_LAT = 15;

  // A lone requester wins; under contention D wins unless D had the
  // previous grant, which keeps the instruction side from starving.
  function automatic owner_t pick_winner(input logic   i_ok,
                                         input logic   d_req,
                                         input owner_t last_grant);
    owner_t win;
    if (d_req && (!i_ok || (last_grant != OWN_D))) begin
      win = OWN_D;
    end else begin
      win = OWN_I;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single memory
// port with fixed read latency MEM_LAT (legal range 1..MAX_LAT). One
// transaction is in flight at a time: IDLE arbitrates, ISSUE strobes the
// command, WAIT counts down the latency and returns the read word to the
// owner. Fetches can be squashed by i_abort; the memory access is still
// drained so the memory never sees a cancelled command.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_abort,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  // memory command port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t       state_reg;
  owner_t           owner_reg;
  owner_t           last_grant_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             squash_reg;

  logic   i_ok;
  logic   any_req;
  logic   ready_pulse;
  logic   abort_hit;
  owner_t winner;

  // Request qualification: an aborting fetch is never granted, and nothing
  // is granted in the ready cycle because the finished requester is still
  // holding its request line during that cycle.
  always_comb begin
    i_ok        = i_req & ~i_abort;
    any_req     = i_ok | d_req;
    ready_pulse = i_ready | d_ready;
    abort_hit   = i_abort & (owner_reg == OWN_I);
    winner      = pick_winner(i_ok, d_req, last_grant_reg);
  end

  // Arbiter FSM with registered memory command and completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= OWN_I;
      last_grant_reg <= OWN_I;
      cnt_reg        <= '0;
      squash_reg     <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      i_ready        <= 1'b0;
      i_rdata        <= '0;
      d_ready        <= 1'b0;
      d_rdata        <= '0;
    end else begin
      // pulses and read data default low; only the completion cycle raises them
      mem_en  <= 1'b0;
      i_ready <= 1'b0;
      i_rdata <= '0;
      d_ready <= 1'b0;
      d_rdata <= '0;

      case (state_reg)
        ST_IDLE: begin
          if (any_req && !ready_pulse) begin
            state_reg      <= ST_ISSUE;
            mem_en         <= 1'b1;
            owner_reg      <= winner;
            last_grant_reg <= winner;
            squash_reg     <= 1'b0;
            if (winner == OWN_D) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_we    <= d_we;
            end else begin
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              mem_we    <= 1'b0;
            end
          end
        end

        ST_ISSUE: begin
          // command strobe is visible this cycle; start the latency count
          mem_we    <= 1'b0;
          cnt_reg   <= CNT_W'(MEM_LAT);
          state_reg <= ST_WAIT;
          if (abort_hit) begin
            squash_reg <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (cnt_reg < CNT_W'(2)) begin
            // response is on mem_rdata now: hand it to the owner
            cnt_reg    <= '0;
            state_reg  <= ST_IDLE;
            squash_reg <= 1'b0;
            if (owner_reg == OWN_D) begin
              d_ready <= 1'b1;
              d_rdata <= mem_rdata;
            end else if (!squash_reg && !i_abort) begin
              i_ready <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (abort_hit) begin
              squash_reg <= 1'b1;
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=2 instance with a pipelined
// memory model and a scoreboard of expected completions, plus MEM_LAT=1 and
// MEM_LAT=15 instances used for latency checks.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance signals
  logic          i_req = 1'b0, i_abort = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_ready, d_ready, mem_en, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  // latency-only instances (A: MEM_LAT=1, B: MEM_LAT=15)
  logic          ia_req = 1'b0, ib_req = 1'b0, tie0 = 1'b0;
  logic [AW-1:0] ia_addr = '0, ib_addr = '0, zaddr = '0;
  logic [DW-1:0] zdata = '0;
  logic          ia_ready, da_ready, mema_en, mema_we;
  logic          ib_ready, db_ready, memb_en, memb_we;
  logic [DW-1:0] ia_rdata, da_rdata, mema_wdata, mema_rdata;
  logic [DW-1:0] ib_rdata, db_rdata, memb_wdata, memb_rdata;
  logic [AW-1:0] mema_addr, memb_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .i_req(ia_req), .i_addr(ia_addr), .i_abort(tie0), .i_ready(ia_ready), .i_rdata(ia_rdata),
    .d_req(tie0), .d_we(tie0), .d_addr(zaddr), .d_wdata(zdata), .d_ready(da_ready), .d_rdata(da_rdata),
    .mem_en(mema_en), .mem_we(mema_we), .mem_addr(mema_addr), .mem_wdata(mema_wdata), .mem_rdata(mema_rdata)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(15)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(ib_req), .i_addr(ib_addr), .i_abort(tie0), .i_ready(ib_ready), .i_rdata(ib_rdata),
    .d_req(tie0), .d_we(tie0), .d_addr(zaddr), .d_wdata(zdata), .d_ready(db_ready), .d_rdata(db_rdata),
    .mem_en(memb_en), .mem_we(memb_we), .mem_addr(memb_addr), .mem_wdata(memb_wdata), .mem_rdata(memb_rdata)
  );

  // the latency-only instances hold mem_addr stable for the whole access,
  // so a combinational address hash serves as their memory
  assign mema_rdata = mema_addr ^ 32'h5A5A_0000;
  assign memb_rdata = memb_addr ^ 32'h5A5A_0000;

  // ---------------- main memory model ----------------
  bit   [255:0]  wvalid;
  bit   [31:0]   warr [256];
  logic [DW-1:0] pipe [LAT];

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    return wvalid[idx] ? warr[idx] : memval(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wvalid[mem_addr[9:2]] <= 1'b1;
      warr[mem_addr[9:2]]   <= mem_wdata;
    end
    pipe[0] <= (mem_en && !mem_we) ? mem_read(mem_addr) : '0;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // ---------------- scoreboard and checking ----------------
  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    sb.push_back(e);
  endtask

  // called at a negedge where a ready pulse is visible
  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_excl"}, 64'(i_ready & d_ready), 64'(0));
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, "_owner_d"}, 64'(d_ready), 64'(e.is_d));
      chk({tag, "_rdata"}, 64'(d_ready ? d_rdata : i_rdata), 64'(e.data));
    end
  endtask

  // no ready pulse and zero read data for n cycles
  task automatic quiet(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk({tag, "_no_ready"}, 64'({i_ready, d_ready}), 64'(0));
      chk({tag, "_rdata_zero"}, 64'({i_rdata, d_rdata}), 64'(0));
    end
  endtask

  // one-gap-cycle, single request; checks the command and completion latency
  task automatic run_txn(input logic is_d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data,
                         input int exp_lat, input string tag);
    bit done;
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    push_exp(is_d, exp_data);
    done = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk({tag, "_mem_en"}, 64'(mem_en), 64'(1));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(addr));
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(we));
        if (we) chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(wdata));
      end else begin
        chk({tag, "_mem_en_low"}, 64'(mem_en), 64'(0));
      end
      if (i_ready || d_ready) begin
        pop_check(tag);
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        done = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      end
    end
    if (!done) chk({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  // fetch latency on one of the MEM_LAT=1 / MEM_LAT=15 instances
  task automatic lat_check(input int which, input logic [31:0] addr, input int exp_lat,
                           input string tag);
    bit done;
    logic rdy;
    logic [31:0] rd;
    @(negedge clk);
    if (which == 1) begin ia_req = 1'b1; ia_addr = addr; end
    else begin ib_req = 1'b1; ib_addr = addr; end
    done = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      rdy = (which == 1) ? ia_ready : ib_ready;
      rd  = (which == 1) ? ia_rdata : ib_rdata;
      if (rdy) begin
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_rdata"}, 64'(rd), 64'(addr ^ 32'h5A5A_0000));
        done = 1'b1;
        ia_req = 1'b0; ib_req = 1'b0;
      end
    end
    if (!done) chk({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_done;
    int exp_cyc;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_strobes", 64'({mem_en, mem_we, i_ready, d_ready}), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
    chk("rst_state", 64'(dut.state_reg), 64'(ST_IDLE));

    // contention from reset: expect D, I, D, I with 5-cycle spacing
    i_req = 1'b1; i_addr = 32'h90;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    push_exp(1'b1, memval(32'h80));
    push_exp(1'b0, memval(32'h90));
    push_exp(1'b1, memval(32'h80));
    push_exp(1'b0, memval(32'h90));
    rst = 1'b0;
    n_done  = 0;
    exp_cyc = 4;
    for (int cyc = 1; cyc <= 40 && n_done < 4; cyc++) begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        pop_check($sformatf("contend%0d", n_done));
        chk($sformatf("contend%0d_cycle", n_done), 64'(cyc), 64'(exp_cyc));
        exp_cyc += 5;
        n_done++;
        if (n_done == 4) begin
          i_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    chk("contend_count", 64'(n_done), 64'(4));
    i_req = 1'b0; d_req = 1'b0;

    // single fetch at 0x10
    run_txn(1'b0, 1'b0, 32'h10, 32'h0, memval(32'h10), LAT + 2, "fetch10");

    // store then load at 0x20
    run_txn(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 32'h0, LAT + 2, "store20");
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, LAT + 2, "load20");

    // a fetch with i_abort high in IDLE must not be granted
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h60; i_abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_idle_no_grant", 64'(mem_en), 64'(0));
    end
    i_req = 1'b0; i_abort = 1'b0;

    // abort during WAIT: access drains, no i_ready, then 0x44 completes
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h30;
    @(negedge clk);
    chk("abort_issue_mem_en", 64'(mem_en), 64'(1));
    @(negedge clk);
    chk("abort_in_wait", 64'(dut.state_reg), 64'(ST_WAIT));
    i_abort = 1'b1; i_req = 1'b0;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort_no_ready_c3", 64'({i_ready, d_ready}), 64'(0));
    quiet(4, "abort_drain");
    chk("abort_back_idle", 64'(dut.state_reg), 64'(ST_IDLE));
    run_txn(1'b0, 1'b0, 32'h44, 32'h0, memval(32'h44), LAT + 2, "fetch44");

    // reset in the middle of WAIT
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_in_wait", 64'(dut.state_reg), 64'(ST_WAIT));
    rst = 1'b1;
    #1;
    chk("midrst_strobes", 64'({mem_en, mem_we, i_ready, d_ready}), 64'(0));
    chk("midrst_mem_addr", 64'(mem_addr), 64'(0));
    chk("midrst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    quiet(6, "midrst_after");
    run_txn(1'b1, 1'b0, 32'h54, 32'h0, memval(32'h54), LAT + 2, "load54");

    // latency extremes
    lat_check(1, 32'h100, 3, "lat1");
    lat_check(2, 32'h200, 17, "lat15");

    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-003 SHALL have parameter MEM_LAT, default 2, meaning the cycles from the mem_en pulse to valid mem_rdata; legal range 1..15.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_req  input  1  fetch request; held with i_addr stable until i_ready or i_abort.
REQ-007 SHALL have port i_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have port i_abort  input  1  squash the pending or in-flight fetch (taken branch).
REQ-009 SHALL have port i_ready  output  1  one-cycle fetch-completion pulse.
REQ-010 SHALL have port i_rdata  output  DATA_W  fetched word; valid only while i_ready=1.
REQ-011 SHALL have port d_req, d_we  input  1 each  data request and write enable; held stable until d_ready.
REQ-012 SHALL have port d_addr, d_wdata  input  ADDR_W, DATA_W  data address and write data.
REQ-013 SHALL have port d_ready  output  1  one-cycle data-completion pulse.
REQ-014 SHALL have port d_rdata  output  DATA_W  load data; valid only while d_ready=1.
REQ-015 SHALL have port mem_en, mem_we  output  1 each  one-cycle memory command strobe and write enable.
REQ-016 SHALL have port mem_addr, mem_wdata  output  ADDR_W, DATA_W  memory command address and data; registered.
REQ-017 SHALL have port mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.

Function
REQ-018 SHALL implement the FSM states IDLE, ISSUE and WAIT, with a one-bit owner register (I or D).
REQ-019 SHALL arbitrate in IDLE when any request is pending: a lone request wins; under contention D wins unless the previous grant was D, in which case I wins.
REQ-020 SHALL NOT grant i_req while i_abort=1 in the same cycle.
REQ-021 SHALL latch the address, write data and write enable of the winner and move IDLE->ISSUE.
REQ-022 SHALL drive mem_en=1 in ISSUE (mem_we=1 only for a D write), load the latency counter with MEM_LAT, and move to WAIT.
REQ-023 SHALL decrement the counter in WAIT; at zero it pulses the owner's ready, passes mem_rdata to that owner's rdata, and returns to IDLE.
REQ-024 SHALL complete a read or write in MEM_LAT+2 cycles from request-sampled to ready; no back-to-back overlap, so the next grant is sampled the cycle after ready.
REQ-025 SHALL, on i_abort=1 while owner=I in ISSUE or WAIT, still issue and drain the memory access, mark it squashed, and suppress i_ready; i_req presented after the drain is arbitrated normally.
REQ-026 SHALL NOT permit a D transaction to be aborted.
REQ-027 SHALL drive i_rdata and d_rdata to zero when their ready is low.
REQ-028 SHALL never assert i_ready and d_ready in the same cycle.
REQ-029 SHALL keep mem_en low outside ISSUE.

Reset
REQ-030 SHALL, on rst=1 at any time, immediately force state=IDLE, counter=0, owner=I, last-grant=I, squash=0, and drive all outputs to 0.
REQ-031 SHALL discard any in-flight memory response that arrives after a mid-transaction reset, with no ready pulse.

Structure
REQ-032 SHALL take its FSM state encoding and owner encoding from a shared package also used by the hazard unit.
REQ-033 SHALL be a single module with no sub-modules; the latency counter width is $clog2(16).

Verification
REQ-034 SHALL verify a fetch: i_req=1, i_addr=0x10, MEM_LAT=2 -> mem_en at cycle 1, i_ready at cycle 4 with i_rdata = the memory word at 0x10.
REQ-035 SHALL verify contention: i_req and d_req both asserted from reset -> grant order D, I, D, I across four consecutive transactions.
REQ-036 SHALL verify a store: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> mem_we=1 with that address and data, d_ready at cycle 4, and a subsequent load from 0x20 returns 0xDEADBEEF.
REQ-037 SHALL verify abort: i_abort=1 during WAIT -> no i_ready pulse, the state returns to IDLE after the drain, and a next i_req to 0x44 completes normally.
REQ-038 SHALL verify reset mid-WAIT: rst pulse -> outputs 0 immediately and no ready pulse afterwards; a new request completes in MEM_LAT+2 cycles.
REQ-039 SHALL verify MEM_LAT=1 and MEM_LAT=15: single-fetch latency is 3 and 17 cycles respectively.
